fb_port_arbiter: RTL and testbench
==================================

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 Parameter CLR_X_MAX, default 640, number of x columns swept by the clear engine.
REQ-002 Parameter CLR_Y_MAX, default 480, number of y rows swept by the clear engine.
REQ-003 iCLK  in  1  single clock; all logic on rising edge.
REQ-004 iRST_N  in  1  asynchronous active-low reset.
REQ-005 iCLR_START  in  1  one-cycle pulse; starts a full-screen clear sweep.
REQ-006 oCLR_BUSY  out  1  high while the clear sweep owns the memory port.
REQ-007 iREQ0 / iREQ1  in  1  client n requests one memory access.
REQ-008 iWE0 / iWE1  in  1  client n access is a write (1) or a read (0).
REQ-009 iADDR0 / iADDR1  in  19  client n address, {x[9:0], y[8:0]}.
REQ-010 iDATA0 / iDATA1  in  1  client n write data.
REQ-011 oGNT0 / oGNT1  out  1  combinational grant; accept occurs in a cycle where iREQn and oGNTn are both high.
REQ-012 oRVALID0 / oRVALID1  out  1  one-cycle strobe; oRDATA holds read data for client n.
REQ-013 oRDATA  out  1  registered read data, shared by both clients.
REQ-014 oMEM_ADDR  out  19  registered address to frame-buffer port A.
REQ-015 oMEM_DATA  out  1  registered write data to port A.
REQ-016 oMEM_WE  out  1  registered write enable to port A.
REQ-017 iMEM_Q  in  1  port A read data; valid one cycle after oMEM_ADDR is presented (synchronous RAM).

Function
REQ-018 States: ARB and CLEAR; reset enters ARB.
REQ-019 ARB to CLEAR on iCLR_START=1; the sweep address starts at {0,0} and oCLR_BUSY rises on the same edge.
REQ-020 In CLEAR, every cycle drives oMEM_WE=1, oMEM_DATA=0 and the sweep address.
- Sweep order: y inner 0..CLR_Y_MAX-1, x outer 0..CLR_X_MAX-1.
- Total of CLR_X_MAX*CLR_Y_MAX writes, with no gaps.
REQ-021 After the write to {CLR_X_MAX-1, CLR_Y_MAX-1}: return to ARB, oCLR_BUSY=0, oMEM_WE=0 on the next edge.
REQ-022 iCLR_START while in CLEAR is ignored; the sweep does not restart.
REQ-023 oGNT0 and oGNT1 are 0 while in CLEAR and in any cycle where iCLR_START=1; the clear engine has top priority.
REQ-024 In ARB, a single requester is granted in the same cycle.
REQ-025 If both clients request, round-robin applies: grant the client not granted last; after reset the preference is client 0.
REQ-026 At most one grant per cycle; throughput is one access per cycle.
REQ-027 Accept in cycle C places that client's addr, data and we on oMEM_* during C+1.
REQ-028 If no accept occurs in a cycle, oMEM_WE=0 next cycle and oMEM_ADDR holds its last value.
REQ-029 A read accepted in cycle C gives oRVALIDn=1 and oRDATA=iMEM_Q during C+3; latency is fixed at 3 and back-to-back reads pipeline.
REQ-030 Writes produce no oRVALID.
REQ-031 Client addresses pass through unchecked; no range clipping.
REQ-032 A client's request stays pending until it is granted; the arbiter never drops a held request.

Reset
REQ-033 On iRST_N=0, the following are cleared asynchronously:
- oMEM_WE, oMEM_DATA, oMEM_ADDR, oRDATA, oRVALID0/1 and oCLR_BUSY all go to 0.
- The round-robin pointer goes to client 0.
- The sweep counters go to 0.
- The read pipeline is flushed.
REQ-034 Reset mid-sweep aborts the clear; reset mid-read drops the pending oRVALID; no restart occurs after release.

Configuration
REQ-035 Macro FB_ARB_PAUSE_EN defined: add input iPAUSE (1 bit).
- While iPAUSE=1, oGNT0/1=0 and the sweep counter holds with oMEM_WE=0.
- The sweep resumes at the held address on release.
- In-flight reads still complete.
REQ-036 FB_ARB_PAUSE_EN undefined: no iPAUSE port exists and behaviour is as if iPAUSE=0.

Verification
REQ-037 Clear with CLR_X_MAX=4, CLR_Y_MAX=3: pulse iCLR_START -> exactly 12 consecutive writes of 0 in order {0,0},{0,1},{0,2},{1,0}..{3,2}, then oCLR_BUSY falls.
REQ-038 Client 0 writes 1 to {320,240}, then client 0 reads {320,240} -> oRVALID0=1 and oRDATA=1 exactly 3 cycles after the read accept.
REQ-039 Both clients hold requests for 6 cycles after reset -> grants alternate 0,1,0,1,0,1.
REQ-040 iCLR_START coincident with iREQ1=1 -> oGNT1=0 for the whole sweep, then iREQ1 is granted in the first ARB cycle.
REQ-041 iRST_N asserted at sweep address {2,1} -> oMEM_WE=0 and oCLR_BUSY=0 immediately; no further writes after release.
REQ-042 With FB_ARB_PAUSE_EN: iPAUSE=1 for 5 cycles mid-sweep -> no writes during the pause and the sweep resumes at the same address.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port A arbiter: two round-robin clients plus a top-priority full-screen clear sweep.
// Optional macro FB_ARB_PAUSE_EN adds iPAUSE, which stalls grants and the sweep.

module fb_port_arbiter #(
    parameter int CLR_X_MAX = 640,
    parameter int CLR_Y_MAX = 480
) (
    input  logic        iCLK,
    input  logic        iRST_N,
`ifdef FB_ARB_PAUSE_EN
    input  logic        iPAUSE,
`endif
    input  logic        iCLR_START,
    output logic        oCLR_BUSY,
    input  logic        iREQ0,
    input  logic        iREQ1,
    input  logic        iWE0,
    input  logic        iWE1,
    input  logic [18:0] iADDR0,
    input  logic [18:0] iADDR1,
    input  logic        iDATA0,
    input  logic        iDATA1,
    output logic        oGNT0,
    output logic        oGNT1,
    output logic        oRVALID0,
    output logic        oRVALID1,
    output logic        oRDATA,
    output logic [18:0] oMEM_ADDR,
    output logic        oMEM_DATA,
    output logic        oMEM_WE,
    input  logic        iMEM_Q
);
    // state | meaning
    // ARB   | clients arbitrated round-robin, one access per cycle
    // CLEAR | sweep engine owns the port, writing zero to every pixel
    typedef enum logic {ARB, CLEAR} state_t;

    localparam logic [9:0]  X_LAST    = 10'(CLR_X_MAX - 1);
    localparam logic [8:0]  Y_LAST    = 9'(CLR_Y_MAX - 1);
    localparam logic [18:0] ADDR_LAST = {X_LAST, Y_LAST};

    function automatic logic [18:0] sweep_inc(input logic [18:0] a);
        logic [18:0] r;
        if (a[8:0] == Y_LAST) r = {a[18:9] + 10'd1, 9'd0};
        else                  r = {a[18:9], a[8:0] + 9'd1};
        return r;
    endfunction

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic [18:0] sweep_q, sweep_d;
    logic [18:0] mem_addr_q, mem_addr_d;
    logic        mem_data_q, mem_data_d;
    logic        mem_we_q, mem_we_d;
    logic        rd_v1_q, rd_id1_q, rd_v2_q, rd_id2_q;
    logic        rvalid0_q, rvalid1_q, rdata_q;
    logic        pause_w, gnt_en, gnt0, gnt1;

`ifdef FB_ARB_PAUSE_EN
    assign pause_w = iPAUSE;
`else
    assign pause_w = 1'b0;
`endif

    // rr_q=1 means client 1 is preferred on a collision
    assign gnt_en = (state_q == ARB) && !iCLR_START && !pause_w;
    assign gnt0   = gnt_en && iREQ0 && (!iREQ1 || !rr_q);
    assign gnt1   = gnt_en && iREQ1 && (!iREQ0 || rr_q);

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        sweep_d    = sweep_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        case (state_q)
            ARB: begin
                if (iCLR_START) begin
                    state_d    = CLEAR;
                    mem_data_d = 1'b0;
                    sweep_d    = '0;
                    if (!pause_w) begin
                        mem_addr_d = '0;
                        mem_we_d   = 1'b1;
                        sweep_d    = sweep_inc(19'd0);
                    end
                end else if (gnt0) begin
                    mem_addr_d = iADDR0;
                    mem_data_d = iDATA0;
                    mem_we_d   = iWE0;
                    rr_d       = 1'b1;
                end else if (gnt1) begin
                    mem_addr_d = iADDR1;
                    mem_data_d = iDATA1;
                    mem_we_d   = iWE1;
                    rr_d       = 1'b0;
                end
            end
            CLEAR: begin
                // sweep_q always holds the next pixel still to be written
                if (mem_we_q && (mem_addr_q == ADDR_LAST)) begin
                    state_d = ARB;
                end else if (!pause_w) begin
                    mem_addr_d = sweep_q;
                    mem_data_d = 1'b0;
                    mem_we_d   = 1'b1;
                    sweep_d    = sweep_inc(sweep_q);
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= ARB;
            rr_q       <= 1'b0;
            sweep_q    <= '0;
            mem_addr_q <= '0;
            mem_data_q <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            sweep_q    <= sweep_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
        end
    end

    // read return: accept -> address out -> RAM data -> registered oRDATA
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rd_v1_q   <= 1'b0;
            rd_id1_q  <= 1'b0;
            rd_v2_q   <= 1'b0;
            rd_id2_q  <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= 1'b0;
        end else begin
            rd_v1_q   <= (gnt0 && !iWE0) || (gnt1 && !iWE1);
            rd_id1_q  <= gnt1;
            rd_v2_q   <= rd_v1_q;
            rd_id2_q  <= rd_id1_q;
            rvalid0_q <= rd_v2_q && !rd_id2_q;
            rvalid1_q <= rd_v2_q && rd_id2_q;
            if (rd_v2_q) rdata_q <= iMEM_Q;
        end
    end

    assign oGNT0     = gnt0;
    assign oGNT1     = gnt1;
    assign oCLR_BUSY = (state_q == CLEAR);
    assign oMEM_ADDR = mem_addr_q;
    assign oMEM_DATA = mem_data_q;
    assign oMEM_WE   = mem_we_q;
    assign oRVALID0  = rvalid0_q;
    assign oRVALID1  = rvalid1_q;
    assign oRDATA    = rdata_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a 4x3 clear window and a behavioural synchronous RAM.
// Define FB_ARB_PAUSE_EN for both bench and RTL to include the pause scenario.

module tb_fb_port_arbiter;
    localparam int XM = 4;
    localparam int YM = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_start, req0, req1, we0, we1, data0, data1;
    logic [18:0] addr0, addr1;
`ifdef FB_ARB_PAUSE_EN
    logic        pause;
`endif
    logic        clr_busy, gnt0, gnt1, rvalid0, rvalid1, rdata;
    logic [18:0] mem_addr;
    logic        mem_data, mem_we, mem_q;

    int vecs = 0;
    int errs = 0;

    bit mem_model [0:524287];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr] <= mem_data;
        mem_q <= mem_model[mem_addr];
    end

    fb_port_arbiter #(.CLR_X_MAX(XM), .CLR_Y_MAX(YM)) dut (
        .iCLK(clk),
        .iRST_N(rst_n),
`ifdef FB_ARB_PAUSE_EN
        .iPAUSE(pause),
`endif
        .iCLR_START(clr_start),
        .oCLR_BUSY(clr_busy),
        .iREQ0(req0),
        .iREQ1(req1),
        .iWE0(we0),
        .iWE1(we1),
        .iADDR0(addr0),
        .iADDR1(addr1),
        .iDATA0(data0),
        .iDATA1(data1),
        .oGNT0(gnt0),
        .oGNT1(gnt1),
        .oRVALID0(rvalid0),
        .oRVALID1(rvalid1),
        .oRDATA(rdata),
        .oMEM_ADDR(mem_addr),
        .oMEM_DATA(mem_data),
        .oMEM_WE(mem_we),
        .iMEM_Q(mem_q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr_start = 1'b0; req0 = 1'b0; req1 = 1'b0;
        we0 = 1'b0; we1 = 1'b0; data0 = 1'b0; data1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        addr0 = '0; addr1 = '0;
`ifdef FB_ARB_PAUSE_EN
        pause = 1'b0;
`endif
        #3;
        if (mem_we !== 1'b0)    begin errs++; $display("FAIL rst_we: got %b want 0", mem_we); end vecs++;
        if (mem_addr !== 19'd0) begin errs++; $display("FAIL rst_addr: got %h want 0", mem_addr); end vecs++;
        if (mem_data !== 1'b0)  begin errs++; $display("FAIL rst_data: got %b want 0", mem_data); end vecs++;
        if (clr_busy !== 1'b0)  begin errs++; $display("FAIL rst_busy: got %b want 0", clr_busy); end vecs++;
        if ({rvalid0, rvalid1, rdata} !== 3'b000) begin errs++; $display("FAIL rst_read: got %b want 000", {rvalid0, rvalid1, rdata}); end vecs++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_clear();
        logic [18:0] ea;
        req0 = 1'b1;
        clr_start = 1'b1;
        @(negedge clk);
        if (gnt0 !== 1'b0) begin errs++; $display("FAIL clr_start_gnt0: got %b want 0", gnt0); end vecs++;
        for (int k = 0; k < 13; k++) begin
            tick();
            req0 = 1'b0;
            clr_start = (k == 5);
            ea = (k < 12) ? {10'(k / 3), 9'(k % 3)} : {10'd3, 9'd2};
            @(negedge clk);
            if (clr_busy !== (k < 12)) begin errs++; $display("FAIL clr_busy[%0d]: got %b want %b", k, clr_busy, k < 12); end vecs++;
            if (mem_we !== (k < 12))   begin errs++; $display("FAIL clr_we[%0d]: got %b want %b", k, mem_we, k < 12); end vecs++;
            if (mem_addr !== ea)       begin errs++; $display("FAIL clr_addr[%0d]: got %h want %h", k, mem_addr, ea); end vecs++;
            if (k < 12 && mem_data !== 1'b0) begin errs++; $display("FAIL clr_data[%0d]: got %b want 0", k, mem_data); end vecs++;
        end
        idle();
    endtask

    task automatic test_write_read();
        tick();
        req0 = 1'b1; we0 = 1'b1; addr0 = {10'd320, 9'd240}; data0 = 1'b1;
        @(negedge clk);
        if ({gnt0, gnt1} !== 2'b10) begin errs++; $display("FAIL wr_gnt: got %b want 10", {gnt0, gnt1}); end vecs++;
        tick();
        we0 = 1'b0; data0 = 1'b0;
        @(negedge clk);
        if (gnt0 !== 1'b1)   begin errs++; $display("FAIL rd_gnt: got %b want 1", gnt0); end vecs++;
        if (mem_we !== 1'b1) begin errs++; $display("FAIL wr_we: got %b want 1", mem_we); end vecs++;
        if (mem_addr !== {10'd320, 9'd240}) begin errs++; $display("FAIL wr_addr: got %h want %h", mem_addr, {10'd320, 9'd240}); end vecs++;
        if (mem_data !== 1'b1) begin errs++; $display("FAIL wr_data: got %b want 1", mem_data); end vecs++;
        tick();
        req0 = 1'b0;
        @(negedge clk);
        if (mem_we !== 1'b0)  begin errs++; $display("FAIL rd_we: got %b want 0", mem_we); end vecs++;
        if (rvalid0 !== 1'b0) begin errs++; $display("FAIL rd_v_c1: got %b want 0", rvalid0); end vecs++;
        tick();
        @(negedge clk);
        if (rvalid0 !== 1'b0) begin errs++; $display("FAIL rd_v_c2: got %b want 0", rvalid0); end vecs++;
        tick();
        @(negedge clk);
        if ({rvalid0, rvalid1, rdata} !== 3'b101) begin errs++; $display("FAIL rd_c3: got %b want 101", {rvalid0, rvalid1, rdata}); end vecs++;
        tick();
        @(negedge clk);
        if (rvalid0 !== 1'b0) begin errs++; $display("FAIL rd_v_c4: got %b want 0", rvalid0); end vecs++;
    endtask

    task automatic test_back_to_back();
        logic [6:0] r0m, r1m, rdm;
        r0m = 7'b0100000;
        r1m = 7'b0011000;
        rdm = 7'b0110000;
        for (int j = 0; j < 7; j++) begin
            tick();
            idle();
            if (j == 0) begin req1 = 1'b1; addr1 = {10'd5, 9'd5}; end
            if (j == 1) begin req1 = 1'b1; addr1 = {10'd320, 9'd240}; end
            if (j == 2) begin req0 = 1'b1; addr0 = {10'd320, 9'd240}; end
            @(negedge clk);
            if (j < 3 && {gnt0, gnt1} !== ((j == 2) ? 2'b10 : 2'b01)) begin errs++; $display("FAIL b2b_gnt[%0d]: got %b", j, {gnt0, gnt1}); end
            if (j < 3) vecs++;
            if (rvalid0 !== r0m[j]) begin errs++; $display("FAIL b2b_v0[%0d]: got %b want %b", j, rvalid0, r0m[j]); end vecs++;
            if (rvalid1 !== r1m[j]) begin errs++; $display("FAIL b2b_v1[%0d]: got %b want %b", j, rvalid1, r1m[j]); end vecs++;
            if ((r0m[j] || r1m[j]) && rdata !== rdm[j]) begin errs++; $display("FAIL b2b_data[%0d]: got %b want %b", j, rdata, rdm[j]); end
            if (r0m[j] || r1m[j]) vecs++;
        end
        idle();
    endtask

    task automatic test_round_robin();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        addr0 = {10'd1, 9'd1}; addr1 = {10'd2, 9'd2};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (gnt0 !== (k % 2 == 0)) begin errs++; $display("FAIL rr_gnt0[%0d]: got %b want %b", k, gnt0, k % 2 == 0); end vecs++;
            if (gnt1 !== (k % 2 == 1)) begin errs++; $display("FAIL rr_gnt1[%0d]: got %b want %b", k, gnt1, k % 2 == 1); end vecs++;
            if (k > 0 && mem_addr !== (((k - 1) % 2 == 0) ? addr0 : addr1)) begin errs++; $display("FAIL rr_addr[%0d]: got %h", k, mem_addr); end
            if (k > 0) vecs++;
            tick();
        end
        idle();
        @(negedge clk);
        if (mem_addr !== {10'd2, 9'd2}) begin errs++; $display("FAIL rr_addr_last: got %h want %h", mem_addr, {10'd2, 9'd2}); end vecs++;
    endtask

    task automatic test_clear_priority();
        tick();
        req1 = 1'b1; we1 = 1'b1; addr1 = {10'd7, 9'd7}; data1 = 1'b1;
        clr_start = 1'b1;
        @(negedge clk);
        if (gnt1 !== 1'b0) begin errs++; $display("FAIL pri_start_gnt1: got %b want 0", gnt1); end vecs++;
        for (int k = 0; k < 12; k++) begin
            tick();
            clr_start = 1'b0;
            @(negedge clk);
            if ({clr_busy, gnt1} !== 2'b10) begin errs++; $display("FAIL pri_sweep[%0d]: busy_gnt got %b want 10", k, {clr_busy, gnt1}); end vecs++;
        end
        tick();
        @(negedge clk);
        if ({clr_busy, gnt1} !== 2'b01) begin errs++; $display("FAIL pri_arb: busy_gnt got %b want 01", {clr_busy, gnt1}); end vecs++;
        tick();
        idle();
        @(negedge clk);
        if ({mem_we, mem_data} !== 2'b11 || mem_addr !== {10'd7, 9'd7}) begin errs++; $display("FAIL pri_access: got we%b d%b a%h", mem_we, mem_data, mem_addr); end vecs++;
    endtask

    task automatic test_reset_mid_sweep();
        tick();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        @(negedge clk);
        if (mem_addr !== {10'd2, 9'd1} || mem_we !== 1'b1) begin errs++; $display("FAIL mid_pre: got we%b a%h want we1 a%h", mem_we, mem_addr, {10'd2, 9'd1}); end vecs++;
        rst_n = 1'b0;
        #1;
        if ({mem_we, clr_busy} !== 2'b00) begin errs++; $display("FAIL mid_rst: we_busy got %b want 00", {mem_we, clr_busy}); end vecs++;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if ({mem_we, clr_busy} !== 2'b00) begin errs++; $display("FAIL mid_post[%0d]: we_busy got %b want 00", k, {mem_we, clr_busy}); end vecs++;
            tick();
        end
    endtask

`ifdef FB_ARB_PAUSE_EN
    task automatic test_pause();
        logic        ew;
        logic [18:0] ea;
        int          idx;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int k = 0; k < 18; k++) begin
            pause = (k >= 4 && k <= 8);
            ew  = (k <= 4) || (k >= 10 && k <= 16);
            idx = (k <= 4) ? k : k - 5;
            ea  = {10'(idx / 3), 9'(idx % 3)};
            @(negedge clk);
            if (mem_we !== ew) begin errs++; $display("FAIL pause_we[%0d]: got %b want %b", k, mem_we, ew); end vecs++;
            if (clr_busy !== (k <= 16)) begin errs++; $display("FAIL pause_busy[%0d]: got %b want %b", k, clr_busy, k <= 16); end vecs++;
            if (ew && mem_addr !== ea) begin errs++; $display("FAIL pause_addr[%0d]: got %h want %h", k, mem_addr, ea); end
            if (ew) vecs++;
            tick();
        end
        pause = 1'b1;
        req0 = 1'b1;
        @(negedge clk);
        if (gnt0 !== 1'b0) begin errs++; $display("FAIL pause_gnt: got %b want 0", gnt0); end vecs++;
        tick();
        pause = 1'b0;
        @(negedge clk);
        if (gnt0 !== 1'b1) begin errs++; $display("FAIL unpause_gnt: got %b want 1", gnt0); end vecs++;
        tick();
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_clear();
        test_write_read();
        test_back_to_back();
        test_round_robin();
        test_clear_priority();
        test_reset_mid_sweep();
`ifdef FB_ARB_PAUSE_EN
        test_pause();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
